// File: rtl/ycr1_wbb_arb_pkg.sv
// ycr1_wbb_arb_pkg: shared types and helpers for the Wishbone burst arbiter
package ycr1_wbb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } arb_state_e;

   // Width of a requester index; a single requester still needs one bit
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ycr1_rr_pick.sv
// ycr1_rr_pick: combinational round-robin picker with optional fixed priority for requester 0
module ycr1_rr_pick
   import ycr1_wbb_arb_pkg::*;
#(
   parameter int NM = 3,
   parameter int GW = idx_w(NM)
) (
   input  logic [NM-1:0] req,
   input  logic [GW-1:0] ptr,
   input  logic          hipri,
   output logic [GW-1:0] gnt_idx,
   output logic          gnt_vld
);

   logic [NM-1:0] req_m;
   logic [GW-1:0] idx;

   // Scan from ptr downwards in reverse so the first request at or after ptr wins
   always_comb begin
      req_m   = hipri ? {req[NM-1:1], 1'b0} : req;
      idx     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int i = NM - 1; i >= 0; i--) begin
         idx = GW'((int'(ptr) + i) % NM);
         if (req_m[idx]) begin
            gnt_idx = idx;
            gnt_vld = 1'b1;
         end
      end
      if (hipri && req[0]) begin
         gnt_idx = '0;
         gnt_vld = 1'b1;
      end
   end

endmodule

// File: rtl/ycr1_wbb_arb.sv
// ycr1_wbb_arb: round-robin Wishbone burst arbiter; YCR1_WBB_ARB_HIPRI_EN gives requester 0 strict priority
module ycr1_wbb_arb
   import ycr1_wbb_arb_pkg::*;
#(
   parameter int NM = 3,
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int BW = 4,
   parameter int BL = 10
) (
   input  logic             wbm_clk_i,
   input  logic             wbm_rst_n,
   input  logic [NM-1:0]    wbm_cyc_i,
   input  logic [NM-1:0]    wbm_stb_i,
   input  logic [NM-1:0]    wbm_we_i,
   input  logic [NM*AW-1:0] wbm_adr_i,
   input  logic [NM*DW-1:0] wbm_dat_i,
   input  logic [NM*BW-1:0] wbm_sel_i,
   input  logic [NM*BL-1:0] wbm_bl_i,
   output logic [DW-1:0]    wbm_dat_o,
   output logic [NM-1:0]    wbm_ack_o,
   output logic [NM-1:0]    wbm_lack_o,
   output logic [NM-1:0]    wbm_err_o,
   output logic             wbs_cyc_o,
   output logic             wbs_stb_o,
   output logic             wbs_we_o,
   output logic [AW-1:0]    wbs_adr_o,
   output logic [DW-1:0]    wbs_dat_o,
   output logic [BW-1:0]    wbs_sel_o,
   output logic [BL-1:0]    wbs_bl_o,
   input  logic [DW-1:0]    wbs_dat_i,
   input  logic             wbs_ack_i,
   input  logic             wbs_lack_i,
   input  logic             wbs_err_i
);

   localparam int GW = idx_w(NM);
`ifdef YCR1_WBB_ARB_HIPRI_EN
   localparam logic HIPRI = 1'b1;
`else
   localparam logic HIPRI = 1'b0;
`endif

   arb_state_e    state_q, state_d;
   logic [GW-1:0] grant_q, grant_d, ptr_q, ptr_d, pick_idx;
   logic [NM-1:0] req, gnt_oh;
   logic          pick_vld, sel, done;

   ycr1_rr_pick #(.NM(NM), .GW(GW)) u_pick (
      .req     (req),
      .ptr     (ptr_q),
      .hipri   (HIPRI),
      .gnt_idx (pick_idx),
      .gnt_vld (pick_vld)
   );

   // A granted requester dropping cyc silences the port in the same cycle
   assign req        = wbm_cyc_i & wbm_stb_i;
   assign sel        = (state_q == BUSY) && wbm_cyc_i[grant_q];
   assign done       = !wbm_cyc_i[grant_q] || wbs_lack_i || (wbs_err_i && wbs_ack_i);
   assign gnt_oh     = sel ? (NM'(1) << grant_q) : '0;
   assign wbm_ack_o  = wbs_ack_i ? gnt_oh : '0;
   assign wbm_lack_o = wbs_lack_i ? gnt_oh : '0;
   assign wbm_err_o  = wbs_err_i ? gnt_oh : '0;
   assign wbm_dat_o  = wbs_dat_i;
   assign wbs_cyc_o  = sel;

   // Command mux from the registered grant; zeros whenever the port is not owned
   always_comb begin
      wbs_stb_o = 1'b0;
      wbs_we_o  = 1'b0;
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_sel_o = '0;
      wbs_bl_o  = '0;
      for (int i = 0; i < NM; i++) begin
         if (sel && grant_q == GW'(i)) begin
            wbs_stb_o = wbm_stb_i[i];
            wbs_we_o  = wbm_we_i[i];
            wbs_adr_o = wbm_adr_i[i*AW +: AW];
            wbs_dat_o = wbm_dat_i[i*DW +: DW];
            wbs_sel_o = wbm_sel_i[i*BW +: BW];
            wbs_bl_o  = wbm_bl_i[i*BL +: BL];
         end
      end
   end

   // Grant on IDLE, hold through the burst, advance ptr past the owner on exit
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      if (state_q == IDLE && pick_vld) begin
         state_d = BUSY;
         grant_d = pick_idx;
      end else if (state_q == BUSY && done) begin
         state_d = GAP;
         ptr_d   = (HIPRI && grant_q == '0) ? ptr_q :
                   (grant_q == GW'(NM - 1)) ? '0 : grant_q + 1'b1;
      end else if (state_q == GAP) begin
         state_d = IDLE;
      end
   end

   // Arbiter state registers
   always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
      if (!wbm_rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule

// File: tb/tb_ycr1_wbb_arb.sv
// tb_ycr1_wbb_arb: directed self-checking bench for ycr1_wbb_arb
module tb_ycr1_wbb_arb;

   localparam int NM = 3, AW = 32, DW = 32, BW = 4, BL = 10;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NM-1:0]    cyc, stb, we;
   logic [NM*AW-1:0] adr;
   logic [NM*DW-1:0] dat;
   logic [NM*BW-1:0] sel;
   logic [NM*BL-1:0] bl;
   logic [DW-1:0]    m_dat;
   logic [NM-1:0]    m_ack, m_lack, m_err;
   logic             s_cyc, s_stb, s_we;
   logic [AW-1:0]    s_adr;
   logic [DW-1:0]    s_dat;
   logic [BW-1:0]    s_sel;
   logic [BL-1:0]    s_bl;
   logic [DW-1:0]    s_rdat;
   logic             s_ack, s_lack, s_err;

   int checks = 0;
   int errors = 0;

   ycr1_wbb_arb #(.NM(NM), .AW(AW), .DW(DW), .BW(BW), .BL(BL)) dut (
      .wbm_clk_i  (clk),
      .wbm_rst_n  (rst_n),
      .wbm_cyc_i  (cyc),
      .wbm_stb_i  (stb),
      .wbm_we_i   (we),
      .wbm_adr_i  (adr),
      .wbm_dat_i  (dat),
      .wbm_sel_i  (sel),
      .wbm_bl_i   (bl),
      .wbm_dat_o  (m_dat),
      .wbm_ack_o  (m_ack),
      .wbm_lack_o (m_lack),
      .wbm_err_o  (m_err),
      .wbs_cyc_o  (s_cyc),
      .wbs_stb_o  (s_stb),
      .wbs_we_o   (s_we),
      .wbs_adr_o  (s_adr),
      .wbs_dat_o  (s_dat),
      .wbs_sel_o  (s_sel),
      .wbs_bl_o   (s_bl),
      .wbs_dat_i  (s_rdat),
      .wbs_ack_i  (s_ack),
      .wbs_lack_i (s_lack),
      .wbs_err_i  (s_err)
   );

   always #5 clk = ~clk;

   task automatic nxt;
      @(negedge clk);
   endtask

   // Requester i uses address 0x1000*(i+1) so the owner is visible on wbs_adr_o
   task automatic rq(input int i, input logic c, input logic w, input logic [BL-1:0] b);
      cyc[i] = c;
      stb[i] = c;
      we[i]  = w;
      adr[i*AW +: AW] = 32'h1000 * (i + 1);
      dat[i*DW +: DW] = 32'hD000 + i;
      sel[i*BW +: BW] = 4'hF;
      bl[i*BL +: BL]  = b;
   endtask

   task automatic rsp(input logic a, input logic l, input logic e);
      s_ack  = a;
      s_lack = l;
      s_err  = e;
   endtask

   task automatic do_reset;
      nxt;
      rst_n = 1'b0;
      cyc = '0; stb = '0; we = '0; adr = '0; dat = '0; sel = '0; bl = '0;
      rsp(0, 0, 0);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      cyc = '0; stb = '0; we = '0; adr = '0; dat = '0; sel = '0; bl = '0;
      rq(1, 1, 0, 4);
      s_rdat = 32'hA5A5_0001;
      rsp(1, 1, 1);
      nxt; nxt; #1;
      checks++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin errors++; $display("FAIL reset_ctl got %b want 000", {s_cyc, s_stb, s_we}); end
      checks++; if ({m_ack, m_lack, m_err} !== '0) begin errors++; $display("FAIL reset_rsp got %b want 0", {m_ack, m_lack, m_err}); end
      checks++; if (s_adr !== '0 || s_bl !== '0) begin errors++; $display("FAIL reset_cmd adr %h bl %0d want 0", s_adr, s_bl); end
      checks++; if (m_dat !== 32'hA5A5_0001) begin errors++; $display("FAIL reset_dat got %h want a5a50001", m_dat); end
      rq(1, 0, 0, 0);
      rsp(0, 0, 0);
      rst_n = 1'b1;
   endtask

   task automatic test_single;
      nxt; rq(1, 1, 0, 4); #1;
      checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL single_idle stb %b want 0", s_stb); end
      nxt;
      for (int b = 0; b < 4; b++) begin
         rsp(1, b == 3, 0);
         s_rdat = 32'hBEEF_0000 + b;
         #1;
         checks++; if (s_stb !== 1'b1 || s_adr !== 32'h2000 || s_bl !== 10'd4 || s_we !== 1'b0) begin errors++; $display("FAIL single_cmd beat %0d stb %b adr %h bl %0d we %b want 1 2000 4 0", b, s_stb, s_adr, s_bl, s_we); end
         checks++; if (m_ack !== 3'b010 || m_lack !== (b == 3 ? 3'b010 : 3'b000)) begin errors++; $display("FAIL single_ack beat %0d ack %b lack %b", b, m_ack, m_lack); end
         checks++; if (m_dat !== 32'hBEEF_0000 + b) begin errors++; $display("FAIL single_dat got %h want %h", m_dat, 32'hBEEF_0000 + b); end
         nxt;
      end
      rsp(0, 0, 0); rq(1, 0, 0, 0); #1;
      checks++; if (s_stb !== 1'b0 || s_cyc !== 1'b0) begin errors++; $display("FAIL single_gap stb %b cyc %b want 0 0", s_stb, s_cyc); end
      nxt;
   endtask

   task automatic test_rr;
      int exp_g [4];
`ifdef YCR1_WBB_ARB_HIPRI_EN
      exp_g = '{0, 0, 0, 0};
`else
      exp_g = '{0, 1, 2, 0};
`endif
      do_reset;
      nxt; rq(0, 1, 1, 1); rq(1, 1, 1, 1); rq(2, 1, 1, 1); #1;
      checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL rr_idle stb %b want 0", s_stb); end
      for (int k = 0; k < 4; k++) begin
         nxt; rsp(1, 1, 0); #1;
         checks++; if (s_stb !== 1'b1 || s_we !== 1'b1 || s_adr !== 32'h1000 * (exp_g[k] + 1)) begin errors++; $display("FAIL rr_grant %0d stb %b we %b adr %h want requester %0d", k, s_stb, s_we, s_adr, exp_g[k]); end
         checks++; if (m_ack !== 3'(1 << exp_g[k]) || m_lack !== 3'(1 << exp_g[k])) begin errors++; $display("FAIL rr_ack %0d ack %b lack %b want %0d", k, m_ack, m_lack, exp_g[k]); end
         nxt; rsp(0, 0, 0);
         if (k == 3) begin rq(0, 0, 0, 0); rq(1, 0, 0, 0); rq(2, 0, 0, 0); end
         #1;
         checks++; if (s_stb !== 1'b0 || m_ack !== '0) begin errors++; $display("FAIL rr_gap %0d stb %b ack %b want 0", k, s_stb, m_ack); end
         nxt; #1;
         checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL rr_arb %0d stb %b want 0", k, s_stb); end
      end
   endtask

   task automatic test_hold;
      do_reset;
      nxt; rq(2, 1, 0, 8); #1;
      nxt; rq(0, 1, 1, 1);
      for (int b = 0; b < 8; b++) begin
         rsp(1, b == 7, 0); #1;
         checks++; if (s_adr !== 32'h3000 || m_ack !== 3'b100) begin errors++; $display("FAIL hold_beat %0d adr %h ack %b want 3000 100", b, s_adr, m_ack); end
         nxt;
      end
      rsp(0, 0, 0); rq(2, 0, 0, 0); #1;
      checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL hold_gap stb %b want 0", s_stb); end
      nxt; nxt; rsp(1, 1, 0); #1;
      checks++; if (s_adr !== 32'h1000 || m_ack !== 3'b001) begin errors++; $display("FAIL hold_next adr %h ack %b want 1000 001", s_adr, m_ack); end
      nxt; rsp(0, 0, 0); rq(0, 0, 0, 0); nxt;
   endtask

   task automatic test_err;
      logic [AW-1:0] exp_a;
`ifdef YCR1_WBB_ARB_HIPRI_EN
      exp_a = 32'h1000;
`else
      exp_a = 32'h3000;
`endif
      do_reset;
      nxt; rq(1, 1, 0, 4);
      nxt; rsp(1, 0, 0); #1;
      checks++; if (m_ack !== 3'b010 || m_err !== 3'b000) begin errors++; $display("FAIL err_beat1 ack %b err %b want 010 000", m_ack, m_err); end
      nxt; rsp(1, 0, 1); #1;
      checks++; if (m_ack !== 3'b010 || m_err !== 3'b010 || m_lack !== 3'b000) begin errors++; $display("FAIL err_beat2 ack %b err %b lack %b want 010 010 000", m_ack, m_err, m_lack); end
      nxt; rsp(1, 0, 0); rq(1, 0, 0, 0); rq(0, 1, 0, 1); rq(2, 1, 0, 1); #1;
      checks++; if (s_stb !== 1'b0 || m_ack !== 3'b000) begin errors++; $display("FAIL err_gap stb %b ack %b want 0 000", s_stb, m_ack); end
      nxt; rsp(0, 0, 0);
      nxt; rsp(1, 1, 0); #1;
      checks++; if (s_adr !== exp_a) begin errors++; $display("FAIL err_ptr adr %h want %h", s_adr, exp_a); end
      nxt; rsp(0, 0, 0); rq(0, 0, 0, 0); rq(2, 0, 0, 0); nxt;
   endtask

   task automatic test_abort;
      do_reset;
      nxt; rq(1, 1, 0, 4);
      nxt; rq(2, 1, 0, 1); rsp(1, 0, 0); #1;
      checks++; if (m_ack !== 3'b010) begin errors++; $display("FAIL abort_beat ack %b want 010", m_ack); end
      nxt; rq(1, 0, 0, 4); #1;
      checks++; if (s_stb !== 1'b0 || s_cyc !== 1'b0 || s_adr !== '0 || m_ack !== 3'b000) begin errors++; $display("FAIL abort_drop stb %b cyc %b adr %h ack %b want 0 0 0 000", s_stb, s_cyc, s_adr, m_ack); end
      nxt; #1;
      checks++; if (s_stb !== 1'b0 || m_ack !== 3'b000) begin errors++; $display("FAIL abort_gap stb %b ack %b want 0 000", s_stb, m_ack); end
      nxt; rsp(0, 0, 0);
      nxt; rsp(1, 1, 0); #1;
      checks++; if (s_adr !== 32'h3000 || m_ack !== 3'b100) begin errors++; $display("FAIL abort_next adr %h ack %b want 3000 100", s_adr, m_ack); end
      nxt; rsp(0, 0, 0); rq(2, 0, 0, 0); nxt;
   endtask

   task automatic test_reset_mid;
      do_reset;
      nxt; rq(0, 1, 0, 1);
      nxt; rsp(1, 1, 0); #1;
      checks++; if (m_ack !== 3'b001) begin errors++; $display("FAIL rmid_first ack %b want 001", m_ack); end
      nxt; rsp(0, 0, 0); rq(0, 0, 0, 0); rq(1, 1, 0, 4);
      nxt;
      nxt; rsp(1, 0, 0); #1;
      checks++; if (s_adr !== 32'h2000 || m_ack !== 3'b010) begin errors++; $display("FAIL rmid_burst adr %h ack %b want 2000 010", s_adr, m_ack); end
      nxt; rq(0, 1, 0, 1); s_rdat = 32'h0000_0077; #2;
      rst_n = 1'b0; #1;
      checks++; if ({s_cyc, s_stb} !== 2'b00 || {m_ack, m_lack, m_err} !== '0) begin errors++; $display("FAIL rmid_async cyc %b stb %b ack %b", s_cyc, s_stb, m_ack); end
      checks++; if (s_adr !== '0 || s_bl !== '0 || m_dat !== 32'h77) begin errors++; $display("FAIL rmid_cmd adr %h bl %0d dat %h want 0 0 77", s_adr, s_bl, m_dat); end
      nxt; rst_n = 1'b1; rsp(0, 0, 0); #1;
      checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL rmid_idle stb %b want 0", s_stb); end
      nxt; rsp(1, 1, 0); #1;
      checks++; if (s_stb !== 1'b1 || s_adr !== 32'h1000 || m_ack !== 3'b001) begin errors++; $display("FAIL rmid_regrant stb %b adr %h ack %b want 1 1000 001", s_stb, s_adr, m_ack); end
      nxt; rsp(0, 0, 0); rq(0, 0, 0, 0); rq(1, 0, 0, 0); nxt;
   endtask

   initial begin
      test_reset;
      test_single;
      test_rr;
      test_hold;
      test_err;
      test_abort;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ycr1_wbb_arb.md
# ycr1_wbb_arb

Round-robin Wishbone burst arbiter that shares the master port of the async Wishbone burst bridge among NM requesters (instruction cache, data cache, direct data memory) in the wbm clock domain. Ownership is granted per transaction and held for the whole burst, until the slave side returns last-ack or error. The block inserts the one-cycle strobe gap that downstream logic requires between transactions.

## Interface
- NM, 3, number of requesters (2..4)
- AW, 32, address width
- DW, 32, data width
- BW, 4, byte-enable width
- BL, 10, burst-count width (1 = one DW beat)
- wbm_clk_i  in  1  clock
- wbm_rst_n  in  1  reset; one clock, reset asynchronous and active-low
- wbm_cyc_i / wbm_stb_i / wbm_we_i  in  NM each  per-requester cycle, strobe, write
- wbm_adr_i  in  NM*AW  per-requester address, packed, requester 0 in LSBs
- wbm_dat_i  in  NM*DW  per-requester write data
- wbm_sel_i  in  NM*BW  per-requester byte enables
- wbm_bl_i  in  NM*BL  per-requester burst count
- wbm_dat_o  out  DW  read data broadcast to all requesters
- wbm_ack_o / wbm_lack_o / wbm_err_o  out  NM each  per-requester ack, last-ack, error
- wbs_cyc_o / wbs_stb_o / wbs_we_o  out  1  to bridge master port
- wbs_adr_o / wbs_dat_o / wbs_sel_o / wbs_bl_o  out  AW/DW/BW/BL  to bridge
- wbs_dat_i  in  DW;  wbs_ack_i / wbs_lack_i / wbs_err_i  in  1  from bridge

## Operation
- States: IDLE, BUSY, GAP.
- IDLE: wbs_cyc_o, wbs_stb_o = 0.
  - Any requester with cyc&stb set → register grant index from the picker; go BUSY.
  - No request → stay IDLE.
- Picker: round-robin. The search starts at ptr and wraps modulo NM. The first asserted request wins.
- BUSY: all wbs_* outputs are the granted requester's inputs, muxed combinationally from the registered grant.
  - wbs_ack_i, wbs_lack_i and wbs_err_i route to the granted bit only. All other requesters see 0.
  - wbm_dat_o = wbs_dat_i unconditionally.
- BUSY exits to GAP on either condition:
  - wbs_lack_i=1, or wbs_err_i=1 together with wbs_ack_i=1 (error is terminal). The terminating response is passed to the requester in the same cycle.
  - The granted requester drops cyc. This is a protocol abort: outputs go low immediately (combinationally), and no response is forwarded afterwards.
- On BUSY exit, ptr ← (grant+1) mod NM.
- GAP: one cycle with wbs_stb_o = wbs_cyc_o = 0, then IDLE. Requests are ignored in GAP.
- Non-granted requesters waiting on a request simply hold stb. They never receive ack while not granted.
- Simultaneous requests in IDLE: only one is granted. The others are guaranteed a grant within NM-1 transactions.
- Reset (asynchronous, at any point, including mid-burst):
  - state IDLE, ptr 0, grant 0.
  - All wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_lack_o, wbm_err_o = 0.
  - wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_bl_o, wbs_we_o = 0 while not BUSY.
  - wbm_dat_o follows wbs_dat_i.

## Timing
- Request asserted in cycle N (IDLE) → wbs_stb_o=1 in cycle N+1.
- Last ack in cycle K → wbs_stb_o=0 in K+1 (GAP). The earliest next grant has wbs_stb_o=1 in K+3.
  - K+2 is IDLE arbitration.
- Response path: zero latency from wbs_* to wbm_* (combinational).
- Command path: grant register plus mux, with no added data latency during a burst. Burst beats flow at the bridge's rate.
- The grant index is stable for the entire BUSY state. It never changes mid-burst.

## Configuration
- YCR1_WBB_ARB_HIPRI_EN defined:
  - Requester 0 has strict priority in IDLE: it wins whenever it is requesting.
  - Requesters 1..NM-1 arbitrate round-robin among themselves. ptr only advances on non-zero grants.
  - Requester 0 still cannot preempt an active burst.
- YCR1_WBB_ARB_HIPRI_EN undefined: pure round-robin over all NM requesters.

## Structure
- Package ycr1_wbb_arb_pkg:
  - state enum (IDLE, BUSY, GAP), 2-bit encoding.
  - grant-index width constant/function, $clog2(NM) with a minimum of 1.
- Sub-module ycr1_rr_pick:
  - Combinational; inputs req[NM], ptr, optional hipri.
  - Outputs gnt_idx and gnt_vld.
  - Reusable by other arbiters.

## Test plan
- Single requester 1, read, bl=4:
  - Expect wbs_stb_o one cycle after request, adr/bl forwarded.
  - Four wbm_ack_o[1] pulses, wbm_lack_o[1] on the 4th, then a 1-cycle stb gap.
- Requesters 0,1,2 all requesting bl=1 writes continuously:
  - Expect grant order 0,1,2,0, each separated by GAP+IDLE (3 cycles from lack to next stb).
  - With HIPRI_EN: order 0,0,0 while req0 held.
- Requester 2 in 8-beat burst while requester 0 asserts:
  - No wbm_ack_o[0] and grant unchanged until lack.
  - Requester 0 granted next.
- wbs_err_i with wbs_ack_i on beat 2 of bl=4:
  - wbm_err_o and ack to granted requester in that cycle, then GAP.
  - ptr advances; no further acks.
- Granted requester drops cyc mid-burst: wbs_stb_o=0 in the same cycle, GAP next, other request served.
- Assert wbm_rst_n=0 mid-burst: all outputs 0 asynchronously, ptr=0. After release, requester 0 and 1 both request → requester 0 granted.
